mem_bus_bridge: RTL and testbench

//   Connects the processor memory port to a variable-latency memory, so the core no longer assumes single-cycle memory.

---
 rtl/mem_bus_bridge.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Bridges the CPU memory port to a variable-latency memory. CPU writes are posted into a
// circular write buffer, reads wait for all earlier writes, and stuck transactions are aborted.
//
// state  | meaning
// IDLE   | no memory transaction; picks the buffer head first, then a pending read
// WDRAIN | head write on the memory bus, waiting for mem_ack
// RREQ   | read request on the memory bus, waiting for mem_ack
// RWAIT  | read accepted, waiting for mem_rvalid
module mem_bus_bridge #(
  parameter int WIDTH   = 16,
  parameter int ADRBITS = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  input  logic [ADRBITS-1:0]      cpu_adr,
  input  logic [WIDTH-1:0]        cpu_wdata,
  output logic [WIDTH-1:0]        cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic                    wr_err,
  output logic [$clog2(DEPTH):0]  wb_count,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADRBITS-1:0]      mem_adr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic                    mem_ack,
  input  logic                    mem_rvalid,
  input  logic [WIDTH-1:0]        mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);
  localparam logic [PW:0]   FULLCNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WDRAIN, RREQ, RWAIT} stateType;

  stateType           state;
  logic [ADRBITS-1:0] adrBuf  [DEPTH];
  logic [WIDTH-1:0]   dataBuf [DEPTH];
  logic [PW-1:0]      headPtr;
  logic [PW-1:0]      tailPtr;
  logic [TW-1:0]      toCnt;
  logic               readPending;
  logic [ADRBITS-1:0] readAdr;

  logic cpuIdle;
  logic bufFull;
  logic bufEmpty;
  logic toHit;
  logic push;
  logic pop;

  // The cycle carrying cpu_ready ignores any still-held request.
  assign cpuIdle  = !readPending && !cpu_ready;
  assign bufFull  = (wb_count == FULLCNT);
  assign bufEmpty = (wb_count == '0);
  assign toHit    = (toCnt >= TLAST);
  assign pop      = (state == WDRAIN) && (mem_ack || toHit);
  assign push     = cpuIdle && cpu_write && !cpu_read && (!bufFull || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      adrBuf[tailPtr]  <= cpu_adr;
      dataBuf[tailPtr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      headPtr     <= '0;
      tailPtr     <= '0;
      wb_count    <= '0;
      toCnt       <= '0;
      readPending <= 1'b0;
      readAdr     <= '0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_err     <= 1'b0;
      wr_err      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_adr     <= '0;
      mem_wdata   <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;

      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      case ({push, pop})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: ;
      endcase

      if (cpuIdle) begin
        if (cpu_read && cpu_write) begin
          cpu_ready <= 1'b1;
          cpu_err   <= 1'b1;
        end else if (push) begin
          cpu_ready <= 1'b1;
        end else if (cpu_read) begin
          readPending <= 1'b1;
          readAdr     <= cpu_adr;
        end
      end

      case (state)
        IDLE: begin
          if (!bufEmpty) begin
            state     <= WDRAIN;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_adr   <= adrBuf[headPtr];
            mem_wdata <= dataBuf[headPtr];
            toCnt     <= '0;
          end else if (readPending) begin
            state   <= RREQ;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            mem_adr <= readAdr;
            toCnt   <= '0;
          end
        end
        WDRAIN: begin
          toCnt <= toCnt + 1'b1;
          if (mem_ack || toHit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_ack) wr_err <= 1'b1;
          end
        end
        RREQ: begin
          toCnt <= toCnt + 1'b1;
          if (mem_ack) begin
            state   <= RWAIT;
            mem_req <= 1'b0;
          end else if (toHit) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            readPending <= 1'b0;
            cpu_ready   <= 1'b1;
            cpu_err     <= 1'b1;
          end
        end
        RWAIT: begin
          toCnt <= toCnt + 1'b1;
          if (mem_rvalid) begin
            state       <= IDLE;
            cpu_rdata   <= mem_rdata;
            cpu_ready   <= 1'b1;
            readPending <= 1'b0;
          end else if (toHit) begin
            state       <= IDLE;
            readPending <= 1'b0;
            cpu_ready   <= 1'b1;
            cpu_err     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: a queue scoreboard checks memory writes and read data,
// plus a second instance with a short timeout for the abort paths.
module tb_mem_bus_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, cpu_err, wr_err;
  logic [2:0]  wb_count;
  logic        mem_req, mem_we;
  logic [15:0] mem_adr, mem_wdata;
  logic        mem_ack, mem_rvalid;
  logic [15:0] mem_rdata;

  logic        tRead, tWrite;
  logic [15:0] tAdr, tWdata, tRdata;
  logic        tReady, tErr, tWrErr;
  logic [2:0]  tCount;
  logic        tReq, tWe;
  logic [15:0] tMemAdr, tMemWdata;
  logic        tAck;

  mem_bus_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .wr_err(wr_err),
    .wb_count(wb_count), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_bus_bridge #(.TIMEOUT(8)) dutTo (
    .clk(clk), .reset(reset),
    .cpu_read(tRead), .cpu_write(tWrite), .cpu_adr(tAdr), .cpu_wdata(tWdata),
    .cpu_rdata(tRdata), .cpu_ready(tReady), .cpu_err(tErr), .wr_err(tWrErr),
    .wb_count(tCount), .mem_req(tReq), .mem_we(tWe), .mem_adr(tMemAdr),
    .mem_wdata(tMemWdata), .mem_ack(tAck), .mem_rvalid(1'b0), .mem_rdata(16'h0000)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [15:0] adr; logic [15:0] data;} wrT;
  wrT          wrQ[$];
  wrT          wrExp;
  logic [15:0] rdQ[$];
  logic [15:0] refMem [logic [15:0]];
  logic [15:0] memArr [logic [15:0]];
  logic [15:0] rdLatch;

  bit ackEnable   = 1'b1;
  int ackDelay    = 0;
  int rvalidDelay = 1;
  int reqCycles   = 0;
  int rvCount     = 0;
  int reqStarts   = 0;
  int cyc         = 0;
  int rvalidCyc   = 0;
  int readyCyc    = 0;
  bit prevReq     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: acks after ackDelay request cycles, returns read data rvalidDelay cycles later.
  always @(negedge clk) begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (reset) begin
      reqCycles = 0;
      rvCount   = 0;
      prevReq   = 1'b0;
    end else begin
      if (rvCount > 0) begin
        rvCount--;
        if (rvCount == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdLatch;
          rvalidCyc  = cyc;
        end
      end
      if (mem_req) begin
        if (!prevReq) begin
          reqStarts++;
          if (!mem_we) chk("rd_after_writes", wrQ.size(), 0);
        end
        if (ackEnable && reqCycles >= ackDelay) begin
          mem_ack   = 1'b1;
          reqCycles = 0;
          if (mem_we) begin
            memArr[mem_adr] = mem_wdata;
            chk("wr_expected", wrQ.size() != 0, 1);
            if (wrQ.size() != 0) begin
              wrExp = wrQ.pop_front();
              chk("mem_adr", mem_adr, wrExp.adr);
              chk("mem_wdata", mem_wdata, wrExp.data);
            end
          end else begin
            rdLatch = memArr.exists(mem_adr) ? memArr[mem_adr] : 16'h0000;
            rvCount = rvalidDelay;
          end
        end else begin
          reqCycles++;
        end
      end
      prevReq = mem_req;
    end
  end

  task automatic waitReady(input string tag, input int maxCyc, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ready && lat < maxCyc);
    readyCyc = cyc;
    chk({tag, "_ready"}, cpu_ready, 1);
  endtask

  task automatic cpuWrite(input logic [15:0] a, input logic [15:0] d, output int lat);
    cpu_write = 1'b1;
    cpu_adr   = a;
    cpu_wdata = d;
    refMem[a] = d;
    wrQ.push_back({a, d});
    waitReady("wr", 50, lat);
    chk("wr_err_pulse", cpu_err, 0);
    cpu_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpuRead(input logic [15:0] a, output int lat);
    logic [15:0] exp;
    cpu_read = 1'b1;
    cpu_adr  = a;
    rdQ.push_back(refMem.exists(a) ? refMem[a] : 16'h0000);
    waitReady("rd", 100, lat);
    exp = rdQ.pop_front();
    chk("rdata", cpu_rdata, exp);
    chk("rd_err", cpu_err, 0);
    cpu_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((wb_count != 0 || mem_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wb_count, 0);
    chk({tag, "_sb"}, wrQ.size(), 0);
  endtask

  task automatic checkResetOuts(input string tag);
    chk({tag, "_ctrl"}, {cpu_ready, cpu_err, wr_err, wb_count, mem_req, mem_we}, 0);
    chk({tag, "_bus"}, {mem_adr, mem_wdata}, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, s0, n, cnt;
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tRead = 1'b0; tWrite = 1'b0; tAdr = '0; tWdata = '0; tAck = 1'b0;
    #12;
    checkResetOuts("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: single write, memory acks in the request cycle
    s0 = reqStarts;
    cpuWrite(16'h0010, 16'hBEEF, lat);
    chk("t1_latency", lat, 1);
    chk("t1_count_busy", wb_count, 1);
    @(negedge clk);
    chk("t1_count_done", wb_count, 0);
    chk("t1_sb", wrQ.size(), 0);
    chk("t1_one_req", reqStarts - s0, 1);

    // 2: fill the buffer with ack withheld, fifth write stalls
    ackEnable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpuWrite(16'h0100 + 16'(i), 16'hA000 + 16'(i), lat);
      chk("t2_fill_latency", lat, 1);
    end
    chk("t2_full", wb_count, 4);
    cpu_write = 1'b1; cpu_adr = 16'h0104; cpu_wdata = 16'hA004;
    refMem[16'h0104] = 16'hA004;
    wrQ.push_back({16'h0104, 16'hA004});
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_ready", cpu_ready, 0);
    end
    chk("t2_stall_count", wb_count, 4);
    ackEnable = 1'b1;
    waitReady("t2_stall", 20, lat);
    chk("t2_post_stall_count", wb_count, 4);
    cpu_write = 1'b0;
    @(negedge clk);
    waitDrain("t2_drain");

    // 3: write then read of the same address, slow acks
    ackDelay = 3;
    s0 = reqStarts;
    cpuWrite(16'h0020, 16'h1234, lat);
    cpuRead(16'h0020, lat);
    chk("t3_reqs", reqStarts - s0, 2);
    chk("t3_data", cpu_rdata, 16'h1234);

    // 4: late read data, exactly one memory request
    ackDelay = 0;
    rvalidDelay = 6;
    s0 = reqStarts;
    cpuRead(16'h0101, lat);
    chk("t4_ready_after_rvalid", readyCyc - rvalidCyc, 1);
    repeat (5) @(negedge clk);
    chk("t4_single_req", reqStarts - s0, 1);

    // illegal simultaneous read and write
    s0 = reqStarts;
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_adr = 16'h0030;
    waitReady("illegal", 10, lat);
    chk("illegal_latency", lat, 1);
    chk("illegal_err", cpu_err, 1);
    cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (4) @(negedge clk);
    chk("illegal_no_mem", reqStarts - s0, 0);
    chk("illegal_count", wb_count, 0);

    // 6a: reset while waiting for read data
    rvalidDelay = 20;
    s0 = reqStarts;
    cpu_read = 1'b1; cpu_adr = 16'h0020;
    n = 0;
    while (!(reqStarts > s0 && !mem_req) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t6a_in_rwait", reqStarts - s0, 1);
    #2 reset = 1'b1;
    #1 checkResetOuts("t6a");
    cpu_read = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    rdQ.delete();
    @(negedge clk);

    // 6b: reset with two writes buffered, then reads after reset
    ackEnable = 1'b0;
    rvalidDelay = 1;
    cpuWrite(16'h0050, 16'h5050, lat);
    cpuWrite(16'h0060, 16'h6060, lat);
    chk("t6b_count", wb_count, 2);
    chk("t6b_req", mem_req, 1);
    #2 reset = 1'b1;
    #1 checkResetOuts("t6b");
    @(negedge clk);
    #1 reset = 1'b0;
    wrQ.delete();
    refMem.delete(16'h0050);
    refMem.delete(16'h0060);
    ackEnable = 1'b1;
    @(negedge clk);
    cpuRead(16'h0010, lat);
    chk("t6b_old_data", cpu_rdata, 16'hBEEF);
    cpuRead(16'h0050, lat);

    // 5: short-timeout instance, read never acked
    tAdr = 16'h0040; tRead = 1'b1;
    n = 0; cnt = 0;
    while (!tReady && n < 40) begin
      @(negedge clk);
      n++;
      if (tReq) cnt++;
    end
    chk("t5_req_cycles", cnt, 8);
    chk("t5_ready", tReady, 1);
    chk("t5_err", tErr, 1);
    chk("t5_rdata", tRdata, 0);
    tRead = 1'b0;
    @(negedge clk);

    tAdr = 16'h0046; tWdata = 16'h1357; tWrite = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!tReady && n < 20);
    chk("t5_wr_ready", tReady, 1);
    chk("t5_wr_err_pulse", tErr, 0);
    tWrite = 1'b0;
    n = 0;
    while (!tReq && n < 20) begin @(negedge clk); n++; end
    chk("t5_wr_req", tReq, 1);
    chk("t5_wr_we", tWe, 1);
    chk("t5_wr_adr", tMemAdr, 16'h0046);
    chk("t5_wr_data", tMemWdata, 16'h1357);
    tAck = 1'b1;
    @(negedge clk);
    tAck = 1'b0;
    @(negedge clk);
    chk("t5_wr_count", tCount, 0);
    chk("t5_wr_no_err", tWrErr, 0);

    // write never acked on the short-timeout instance
    tAdr = 16'h0044; tWdata = 16'h5555; tWrite = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!tReady && n < 20);
    tWrite = 1'b0;
    n = 0; cnt = 0;
    while (!tWrErr && n < 40) begin
      @(negedge clk);
      n++;
      if (tReq) cnt++;
    end
    chk("t5_wdrain_cycles", cnt, 8);
    chk("t5_wr_err", tWrErr, 1);
    chk("t5_dropped_count", tCount, 0);
    chk("t5_req_dropped", tReq, 0);
    repeat (3) @(negedge clk);
    chk("t5_wr_err_sticky", tWrErr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
